// File: rtl/shape_plotter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shape_plotter_pkg                                                    |
// | Shared state encoding, mode codes and Q12 constants for the plotter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package shape_plotter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PLOT  = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic MODE_CIRCLE   = 1'b0;
  localparam logic MODE_REULEAUX = 1'b1;

  localparam logic [11:0] SQRT3_6 = 12'd1182;
  localparam logic [11:0] SQRT3_3 = 12'd2365;

  // Multiply by a Q12 fraction and round to nearest.
  function automatic logic [31:0] q12_round(input logic [31:0] a, input logic [11:0] c);
    return (a * {20'd0, c} + 32'd2048) >> 12;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shape_plotter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shape_plotter_if                                                     |
// | Draw request/done handshake plus the VGA plot port with back-pressure|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface shape_plotter_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int SW = 8
) ();
  logic          start;
  logic          mode;
  logic [2:0]    colour;
  logic [XW-1:0] centre_x;
  logic [YW-1:0] centre_y;
  logic [SW-1:0] size;
  logic          done;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;
  logic          vga_ready;

  modport master (
    output start, mode, colour, centre_x, centre_y, size, vga_ready,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, mode, colour, centre_x, centre_y, size, vga_ready,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface
`default_nettype wire

// File: rtl/shape_plotter_stepper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bresenham_stepper                                                    |
// | Midpoint circle octant walker: ox/oy/crit state and the oy<=ox test. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bresenham_stepper #(
  parameter int SW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_i,
  input  logic                 step_i,
  input  logic [SW-1:0]        size_i,
  output logic signed [SW+1:0] ox_o,
  output logic signed [SW+1:0] oy_o,
  output logic                 more_o
);
  typedef logic signed [SW+1:0] off_t;
  typedef logic signed [SW+2:0] crit_t;

  off_t  ox_q, oy_q, ox_d, oy_d;
  crit_t crit_q, crit_d;

  // more_o judges the post-step offsets so the FSM can branch in STEP itself.
  always_comb begin
    oy_d = oy_q + off_t'(1);
    if (crit_q <= crit_t'(0)) begin
      ox_d   = ox_q;
      crit_d = crit_q + (crit_t'(oy_d) <<< 1) + crit_t'(1);
    end else begin
      ox_d   = ox_q - off_t'(1);
      crit_d = crit_q + (crit_t'(oy_d - ox_d) <<< 1) + crit_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ox_q   <= '0;
      oy_q   <= '0;
      crit_q <= '0;
    end else if (init_i) begin
      ox_q   <= off_t'({2'b00, size_i});
      oy_q   <= '0;
      crit_q <= crit_t'(1) - crit_t'({3'b000, size_i});
    end else if (step_i) begin
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      crit_q <= crit_d;
    end
  end

  assign ox_o   = ox_q;
  assign oy_o   = oy_q;
  assign more_o = (oy_d <= ox_d);

endmodule
`default_nettype wire

// File: rtl/shape_plotter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shape_plotter                                                        |
// | Circle / Reuleaux outline engine with clipping and plot back-pressure|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shape_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int SW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  shape_plotter_if.slave  bus
);
  import shape_plotter_pkg::*;

  // Wide enough that no slot coordinate can wrap for any legal input.
  localparam int MW = (XW > YW) ? XW : YW;
  localparam int CW = ((MW > SW) ? MW : SW) + 3;
  typedef logic signed [CW-1:0] coord_t;
  localparam coord_t C_SCREEN_W = coord_t'(SCREEN_W);
  localparam coord_t C_SCREEN_H = coord_t'(SCREEN_H);

  state_t        state_q, state_d;
  logic          mode_q;
  logic [2:0]    colour_q;
  coord_t        cx_q, cy_q, v1x_q, v2x_q, vy_q, v3y_q;
  logic [SW-1:0] size_q;
  logic [2:0]    slot_q;

  logic signed [SW+1:0] w_ox_s, w_oy_s;
  logic          w_more_rows;
  coord_t        w_ox, w_oy, w_half, w_h, w_k;
  coord_t        w_sx [8];
  coord_t        w_sy [8];
  logic [7:0]    w_gate, w_vis;
  logic          w_found, w_more;
  logic [2:0]    w_fidx;
  logic          w_accept;

  bresenham_stepper #(.SW(SW)) u_stepper (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_i (state_q == SETUP),
    .step_i (state_q == STEP),
    .size_i (size_q),
    .ox_o   (w_ox_s),
    .oy_o   (w_oy_s),
    .more_o (w_more_rows)
  );

  assign w_ox   = coord_t'(w_ox_s);
  assign w_oy   = coord_t'(w_oy_s);
  assign w_half = coord_t'({{(CW-SW){1'b0}}, size_q} >> 1);
  assign w_h    = coord_t'(q12_round(32'(size_q), SQRT3_6));
  assign w_k    = coord_t'(q12_round(32'(size_q), SQRT3_3));

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_sx[i] = '0;
      w_sy[i] = '0;
    end
    w_gate = 8'hFF;
    if (mode_q == MODE_CIRCLE) begin
      w_sx[0] = cx_q + w_ox; w_sy[0] = cy_q + w_oy;
      w_sx[1] = cx_q + w_oy; w_sy[1] = cy_q + w_ox;
      w_sx[2] = cx_q - w_oy; w_sy[2] = cy_q + w_ox;
      w_sx[3] = cx_q - w_ox; w_sy[3] = cy_q + w_oy;
      w_sx[4] = cx_q - w_ox; w_sy[4] = cy_q - w_oy;
      w_sx[5] = cx_q - w_oy; w_sy[5] = cy_q - w_ox;
      w_sx[6] = cx_q + w_oy; w_sy[6] = cy_q - w_ox;
      w_sx[7] = cx_q + w_ox; w_sy[7] = cy_q - w_oy;
    end else begin
      // Each arc is centred on one vertex and bounded by the other two.
      w_sx[0] = cx_q + w_oy;  w_sy[0] = v3y_q + w_ox;
      w_sx[1] = cx_q - w_oy;  w_sy[1] = v3y_q + w_ox;
      w_sx[2] = v1x_q - w_ox; w_sy[2] = vy_q - w_oy;
      w_sx[3] = v1x_q - w_oy; w_sy[3] = vy_q - w_ox;
      w_sx[4] = v2x_q + w_ox; w_sy[4] = vy_q - w_oy;
      w_sx[5] = v2x_q + w_oy; w_sy[5] = vy_q - w_ox;
      w_gate  = {2'b00, (w_sx[5] >= cx_q), 1'b1, (w_sx[3] <= cx_q), 1'b1,
                 (w_sx[1] >= v2x_q), (w_sx[0] <= v1x_q)};
    end
    for (int i = 0; i < 8; i++) begin
      w_vis[i] = w_gate[i] && (w_sx[i] >= coord_t'(0)) && (w_sx[i] < C_SCREEN_W) &&
                 (w_sy[i] >= coord_t'(0)) && (w_sy[i] < C_SCREEN_H);
    end
  end

  // First visible slot at or after slot_q, and whether another follows it.
  always_comb begin
    w_found = 1'b0;
    w_more  = 1'b0;
    w_fidx  = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_vis[i] && (3'(i) >= slot_q)) begin
        if (w_found) begin
          w_more = 1'b1;
        end else begin
          w_found = 1'b1;
          w_fidx  = 3'(i);
        end
      end
    end
  end

  assign w_accept = (state_q == PLOT) && w_found && bus.vga_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SETUP;
      SETUP:   state_d = PLOT;
      PLOT:    if (!w_found || (w_accept && !w_more)) state_d = STEP;
      STEP:    state_d = w_more_rows ? PLOT : DONE;
      DONE:    if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.done       = (state_q == DONE);
    bus.vga_plot   = (state_q == PLOT) && w_found;
    bus.vga_colour = colour_q;
    bus.vga_x      = bus.vga_plot ? w_sx[w_fidx][XW-1:0] : '0;
    bus.vga_y      = bus.vga_plot ? w_sy[w_fidx][YW-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= MODE_CIRCLE;
      colour_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      size_q   <= '0;
      v1x_q    <= '0;
      v2x_q    <= '0;
      vy_q     <= '0;
      v3y_q    <= '0;
      slot_q   <= '0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        mode_q   <= bus.mode;
        colour_q <= bus.colour;
        cx_q     <= coord_t'({{(CW-XW){1'b0}}, bus.centre_x});
        cy_q     <= coord_t'({{(CW-YW){1'b0}}, bus.centre_y});
        size_q   <= bus.size;
      end
      if (state_q == SETUP) begin
        v1x_q <= cx_q + w_half;
        v2x_q <= cx_q - w_half;
        vy_q  <= cy_q + w_h;
        v3y_q <= cy_q - w_k;
      end
      if (state_q == SETUP || state_q == STEP) slot_q <= '0;
      else if (w_accept)                       slot_q <= w_fidx + 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shape_plotter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shape_plotter                                                     |
// | Scoreboard bench: a software shape model feeds an expected-pixel queue|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_shape_plotter;
  import shape_plotter_pkg::*;

  localparam int XW = 8, YW = 7, SW = 8;
  localparam int SCREEN_W = 160, SCREEN_H = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shape_plotter_if #(.XW(XW), .YW(YW), .SW(SW)) bus ();

  shape_plotter #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .XW(XW), .YW(YW), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int stalls = 0;
  bit seen_a, seen_b, seen_c;
  bit prev_stall = 1'b0;
  int prev_x, prev_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: enumerates the visible pixels of a shape in plot order.
  task automatic push_shape(input bit m, input int cx, input int cy, input int size, input int col);
    int ox, oy, crit, h, k, v1x, v2x, vy, v3y, n;
    int xs[8];
    int ys[8];
    bit g[8];
    pix_t p;
    ox = size; oy = 0; crit = 1 - size;
    h = (size * 1182 + 2048) / 4096;
    k = (size * 2365 + 2048) / 4096;
    v1x = cx + size / 2; v2x = cx - size / 2; vy = cy + h; v3y = cy - k;
    while (oy <= ox) begin
      g = '{default: 1'b1};
      if (!m) begin
        n  = 8;
        xs = '{cx+ox, cx+oy, cx-oy, cx-ox, cx-ox, cx-oy, cx+oy, cx+ox};
        ys = '{cy+oy, cy+ox, cy+ox, cy+oy, cy-oy, cy-ox, cy-ox, cy-oy};
      end else begin
        n  = 6;
        xs[0] = cx + oy;   ys[0] = v3y + ox; g[0] = (xs[0] <= v1x);
        xs[1] = cx - oy;   ys[1] = v3y + ox; g[1] = (xs[1] >= v2x);
        xs[2] = v1x - ox;  ys[2] = vy - oy;
        xs[3] = v1x - oy;  ys[3] = vy - ox;  g[3] = (xs[3] <= cx);
        xs[4] = v2x + ox;  ys[4] = vy - oy;
        xs[5] = v2x + oy;  ys[5] = vy - ox;  g[5] = (xs[5] >= cx);
      end
      for (int i = 0; i < n; i++) begin
        if (g[i] && xs[i] >= 0 && xs[i] < SCREEN_W && ys[i] >= 0 && ys[i] < SCREEN_H) begin
          p.x = xs[i]; p.y = ys[i]; p.c = col;
          exp_q.push_back(p);
        end
      end
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end
  endtask

  // Output monitor: pops the scoreboard on every accepted pixel.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_plot", 32'(bus.vga_plot), 32'd1);
          check("hold_x", 32'(bus.vga_x), prev_x);
          check("hold_y", 32'(bus.vga_y), prev_y);
        end
        prev_stall = bus.vga_plot && !bus.vga_ready;
        prev_x = int'(bus.vga_x);
        prev_y = int'(bus.vga_y);
        if (prev_stall) stalls++;
        if (bus.vga_plot && bus.vga_ready) begin
          pulses++;
          check("x_on_screen", 32'(int'(bus.vga_x) < SCREEN_W), 32'd1);
          check("y_on_screen", 32'(int'(bus.vga_y) < SCREEN_H), 32'd1);
          if (bus.vga_x == 8'd80  && bus.vga_y == 7'd77) seen_a = 1'b1;
          if (bus.vga_x == 8'd60  && bus.vga_y == 7'd72) seen_b = 1'b1;
          if (bus.vga_x == 8'd100 && bus.vga_y == 7'd72) seen_c = 1'b1;
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL extra_pulse: observed=(%0d,%0d) expected=no pixel", bus.vga_x, bus.vga_y);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pix_x", 32'(bus.vga_x), e.x);
            check("pix_y", 32'(bus.vga_y), e.y);
            check("pix_colour", 32'(bus.vga_colour), e.c);
          end
        end
      end
    end
  end

  task automatic drive_req(input bit m, input int cx, input int cy, input int size, input int col);
    bus.mode     = m;
    bus.centre_x = XW'(cx);
    bus.centre_y = YW'(cy);
    bus.size     = SW'(size);
    bus.colour   = 3'(col);
    bus.start    = 1'b1;
  endtask

  // Draw one shape to completion, then verify the DONE handshake.
  task automatic run_shape(input string tag, input bit m, input int cx, input int cy,
                           input int size, input int col, input bit bp);
    int n_exp, cyc;
    pulses = 0;
    stalls = 0;
    push_shape(m, cx, cy, size, col);
    n_exp = exp_q.size();
    bus.vga_ready = 1'b1;
    drive_req(m, cx, cy, size, col);
    cyc = 0;
    while (!bus.done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (bp) bus.vga_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
    bus.vga_ready = 1'b1;
    check({tag, "_done_rise"}, 32'(bus.done), 32'd1);
    check({tag, "_pulse_count"}, pulses, n_exp);
    check({tag, "_queue_left"}, exp_q.size(), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check({tag, "_done_held"}, 32'(bus.done), 32'd1);
    end
    check({tag, "_no_retrigger"}, pulses, n_exp);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0; bus.mode = MODE_CIRCLE; bus.colour = '0;
    bus.centre_x = '0; bus.centre_y = '0; bus.size = '0; bus.vga_ready = 1'b1;
    seen_a = 1'b0; seen_b = 1'b0; seen_c = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_plot", 32'(bus.vga_plot), 32'd0);
    check("rst_x", 32'(bus.vga_x), 32'd0);
    check("rst_y", 32'(bus.vga_y), 32'd0);
    check("rst_colour", 32'(bus.vga_colour), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_shape("circ10", MODE_CIRCLE, 80, 60, 10, 5, 1'b0);
    check("circ10_64_pulses", pulses, 32'd64);

    run_shape("clip", MODE_CIRCLE, 2, 2, 10, 3, 1'b0);

    run_shape("reul", MODE_REULEAUX, 80, 60, 40, 6, 1'b0);
    check("reul_seen_80_77", 32'(seen_a), 32'd1);
    check("reul_seen_60_72", 32'(seen_b), 32'd1);
    check("reul_seen_100_72", 32'(seen_c), 32'd1);

    run_shape("bp", MODE_CIRCLE, 40, 30, 3, 2, 1'b1);
    check("bp_stalls_seen", 32'(stalls > 0), 32'd1);

    // Abort mid-draw, then redraw the full shape from scratch.
    pulses = 0;
    push_shape(MODE_CIRCLE, 80, 60, 10, 4);
    drive_req(MODE_CIRCLE, 80, 60, 10, 4);
    cyc = 0;
    while (pulses < 10 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reached", 32'(pulses >= 10), 32'd1);
    check("abort_plot_before", 32'(bus.vga_plot), 32'd1);
    rst_n = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("abort_plot", 32'(bus.vga_plot), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_shape("redraw", MODE_CIRCLE, 80, 60, 10, 4, 1'b0);
    check("redraw_64_pulses", pulses, 32'd64);

    run_shape("size0", MODE_CIRCLE, 50, 40, 0, 7, 1'b0);
    check("size0_8_pulses", pulses, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
